// File: rtl/result_select_pipe_pkg.sv
// Shared types and datapath defaults for the result selector pipeline.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package result_select_pipe_pkg;

    // Datapath defaults for the 16-bit core result bus
    localparam int DP_WIDTH     = 16;
    localparam int DP_SEL_W     = 3;
    localparam int DP_NUM_SRC   = 6;
    localparam int DP_ERR_CNT_W = 8;

    // Occupancy of the output/skid register pair
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

endpackage

// File: rtl/result_select_pipe_if.sv
// Handshake bundle between result producers, the selector and writeback.
// Latency: n/a (wires only).
// Backpressure: in_ready/out_ready valid-ready pairs on both sides.
interface result_select_pipe_if #(
    parameter int WIDTH   = 16,
    parameter int NUM_SRC = 6,
    parameter int SEL_W   = 3
);
    logic                     in_valid;
    logic                     in_ready;
    logic [NUM_SRC*WIDTH-1:0] src_data;
    logic [SEL_W-1:0]         sel;
    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH-1:0]         out_data;
    logic                     out_sel_err;

    // Selector side
    modport slave (
        input  in_valid, src_data, sel, out_ready,
        output in_ready, out_valid, out_data, out_sel_err
    );

    // Producer/consumer side
    modport master (
        output in_valid, src_data, sel, out_ready,
        input  in_ready, out_valid, out_data, out_sel_err
    );
endinterface

// File: rtl/result_select_pipe_mux.sv
// Combinational NUM_SRC:1 word select; out-of-range index gives zero data and err.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller qualifies with its own handshake.
module result_select_mux #(
    parameter int WIDTH   = 16,
    parameter int NUM_SRC = 6,
    parameter int SEL_W   = 3
) (
    input  logic [NUM_SRC*WIDTH-1:0] src_data_i,
    input  logic [SEL_W-1:0]         sel_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     err_o
);

    // Zero data and flag an error unless sel hits an existing source
    always_comb begin
        data_o = '0;
        err_o  = 1'b1;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (sel_i == SEL_W'(k)) begin
                data_o = src_data_i[k*WIDTH +: WIDTH];
                err_o  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/result_select_pipe.sv
// Registered result selector with a 2-entry skid (output reg O + skid reg S).
// Latency: 1 cycle from accept to out_valid; one transfer per cycle sustained.
// Backpressure: in_ready decoded from registered state only (no out_ready->in_ready path).
module result_select_pipe
    import result_select_pipe_pkg::*;
#(
    parameter int WIDTH     = DP_WIDTH,
    parameter int NUM_SRC   = DP_NUM_SRC,
    parameter int SEL_W     = DP_SEL_W,
    parameter int ERR_CNT_W = DP_ERR_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    result_select_pipe_if.slave  bus,
    output logic [ERR_CNT_W-1:0] err_count
);

    state_e               state_q, state_d;
    logic                 in_rdy, out_vld;
    logic                 push, pop;
    logic [WIDTH-1:0]     mux_data;
    logic                 mux_err;
    logic                 o_load, o_from_s, s_load;
    logic [WIDTH-1:0]     o_data_q, s_data_q;
    logic                 o_err_q, s_err_q;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

    result_select_mux #(
        .WIDTH   (WIDTH),
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W)
    ) u_mux (
        .src_data_i (bus.src_data),
        .sel_i      (bus.sel),
        .data_o     (mux_data),
        .err_o      (mux_err)
    );

    assign in_rdy          = (state_q != ST_FULL);
    assign out_vld         = (state_q != ST_EMPTY);
    assign push            = bus.in_valid && in_rdy;
    assign pop             = out_vld && bus.out_ready;
    assign bus.in_ready    = in_rdy;
    assign bus.out_valid   = out_vld;
    assign bus.out_data    = o_data_q;
    assign bus.out_sel_err = o_err_q;
    assign err_count       = err_count_q;

    // Occupancy transitions and register load strobes; flush overrides everything
    always_comb begin
        state_d  = state_q;
        o_load   = 1'b0;
        o_from_s = 1'b0;
        s_load   = 1'b0;
        unique case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    o_load  = 1'b1;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (push && !pop) begin
                    s_load  = 1'b1;
                    state_d = ST_FULL;
                end else if (push && pop) begin
                    o_load  = 1'b1;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    o_from_s = 1'b1;
                    state_d  = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
            state_d  = ST_EMPTY;
            o_load   = 1'b0;
            o_from_s = 1'b0;
            s_load   = 1'b0;
        end
    end

    // Bad-select counter, saturating; the flush cycle's transfer is discarded
    always_comb begin
        err_count_d = err_count_q;
        if (push && mux_err && !flush && (err_count_q != {ERR_CNT_W{1'b1}}))
            err_count_d = err_count_q + ERR_CNT_W'(1);
    end

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            err_count_q <= err_count_d;
        end
    end

    // Output register: new word on direct load, skid word on drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_data_q <= '0;
            o_err_q  <= 1'b0;
        end else if (o_load) begin
            o_data_q <= mux_data;
            o_err_q  <= mux_err;
        end else if (o_from_s) begin
            o_data_q <= s_data_q;
            o_err_q  <= s_err_q;
        end
    end

    // Skid register: parks the word accepted while O is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_data_q <= '0;
            s_err_q  <= 1'b0;
        end else if (s_load) begin
            s_data_q <= mux_data;
            s_err_q  <= mux_err;
        end
    end

endmodule

// File: tb/tb_result_select_pipe.sv
// Scoreboard bench for result_select_pipe: directed transfers, stalls, flush, reset.
// Latency: expects output one edge after accept.
// Backpressure: drives out_ready patterns and checks in_ready/hold behaviour.
module tb_result_select_pipe;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic [7:0] err_count;
    logic [1:0] err_count2;

    int checks   = 0;
    int failures = 0;

    logic [16:0] exp_q[$];   // {err, data}
    logic        stall_chk = 1'b0;
    logic [15:0] stall_dat = '0;

    result_select_pipe_if #(.WIDTH(16), .NUM_SRC(6), .SEL_W(3)) bus  ();
    result_select_pipe_if #(.WIDTH(16), .NUM_SRC(6), .SEL_W(3)) bus2 ();

    result_select_pipe #(.WIDTH(16), .NUM_SRC(6), .SEL_W(3), .ERR_CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .bus       (bus),
        .err_count (err_count)
    );

    result_select_pipe #(.WIDTH(16), .NUM_SRC(6), .SEL_W(3), .ERR_CNT_W(2)) dut_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (1'b0),
        .bus       (bus2),
        .err_count (err_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Source k carries {k, tag}
    function automatic logic [95:0] src_of(input logic [11:0] tag);
        logic [95:0] v;
        v = '0;
        for (int k = 0; k < 6; k++) v[k*16 +: 16] = {4'(k), tag};
        return v;
    endfunction

    // Present one word until accepted; expectation queued at the accepting edge
    task automatic send(input logic [95:0] src, input logic [2:0] s,
                        input logic [15:0] exp_d, input logic exp_e);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.src_data = src;
        bus.sel      = s;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", n);
        end else begin
            exp_q.push_back({exp_e, exp_d});
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: %0d entries left, required 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every popped word against the scoreboard, check stall stability
    always @(negedge clk) begin
        logic [16:0] e;
        if (stall_chk && bus.out_valid)
            chk("stall_stable", 32'(bus.out_data), 32'(stall_dat));
        stall_chk = bus.out_valid && !bus.out_ready;
        stall_dat = bus.out_data;
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out: got %0h with empty scoreboard", bus.out_data);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", 32'(bus.out_data), 32'(e[15:0]));
                chk("out_sel_err", 32'(bus.out_sel_err), 32'(e[16]));
            end
        end
    end

    initial begin
        logic [3:0] pat;
        logic       stream_done;
        logic [1:0] sat_exp [5];
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.src_data  = '0;
        bus.sel       = '0;
        bus.out_ready = 1'b0;
        bus2.in_valid = 1'b0;
        bus2.src_data = '0;
        bus2.sel      = 3'd7;
        bus2.out_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_sel_err", 32'(bus.out_sel_err), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // First transfer: visible right after the accepting edge
        bus.out_ready = 1'b1;
        send({16'h5555, 16'h4444, 16'h3333, 16'hBEEF, 16'h1111, 16'h0000}, 3'd2, 16'hBEEF, 1'b0);
        chk("lat_out_valid", 32'(bus.out_valid), 32'd1);
        chk("lat_out_data", 32'(bus.out_data), 32'hBEEF);
        wait_drain();

        // Out-of-range selects
        send(src_of(12'h777), 3'd6, 16'h0000, 1'b1);
        chk("err_count_1", 32'(err_count), 32'd1);
        send(src_of(12'h777), 3'd7, 16'h0000, 1'b1);
        chk("err_count_2", 32'(err_count), 32'd2);
        wait_drain();

        // Fill both registers under stall, third push must be held
        bus.out_ready = 1'b0;
        send(src_of(12'hA01), 3'd0, 16'h0A01, 1'b0);
        chk("one_in_ready", 32'(bus.in_ready), 32'd1);
        send(src_of(12'hB02), 3'd1, 16'h1B02, 1'b0);
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        fork
            send(src_of(12'hC03), 3'd5, 16'h5C03, 1'b0);
            begin
                repeat (3) @(negedge clk);
                chk("held_in_ready", 32'(bus.in_ready), 32'd0);
                chk("held_out_data", 32'(bus.out_data), 32'h0A01);
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        wait_drain();
        chk("drained_in_ready", 32'(bus.in_ready), 32'd1);

        // 100-word stream with out_ready pattern 1,0,0,1
        stream_done = 1'b0;
        pat = 4'b1001;
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    logic [2:0]  s;
                    logic [15:0] d;
                    s = 3'(i % 8);
                    d = (s < 3'd6) ? {1'b0, s, 12'(i)} : 16'h0000;
                    send(src_of(12'(i)), s, d, (s >= 3'd6));
                end
                stream_done = 1'b1;
            end
            begin
                int ph;
                ph = 0;
                while (!stream_done) begin
                    bus.out_ready = pat[ph];
                    ph = (ph + 1) % 4;
                    @(posedge clk);
                    #1;
                end
            end
        join
        bus.out_ready = 1'b1;
        wait_drain();
        chk("stream_err_count", 32'(err_count), 32'd26);

        // Flush from FULL
        bus.out_ready = 1'b0;
        send(src_of(12'hD01), 3'd3, 16'h3D01, 1'b0);
        send(src_of(12'hD02), 3'd6, 16'h0000, 1'b1);
        chk("pre_flush_in_ready", 32'(bus.in_ready), 32'd0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        exp_q.delete();
        chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
        chk("flush_err_count", 32'(err_count), 32'd27);

        // Flush with a bad-sel word accepted in the same cycle: discarded, not counted
        send(src_of(12'hE01), 3'd4, 16'h4E01, 1'b0);
        bus.in_valid = 1'b1;
        bus.src_data = src_of(12'hE02);
        bus.sel      = 3'd7;
        flush        = 1'b1;
        @(posedge clk);
        #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        exp_q.delete();
        chk("flush2_out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush2_err_count", 32'(err_count), 32'd27);

        // Reset from FULL
        send(src_of(12'hF01), 3'd1, 16'h1F01, 1'b0);
        send(src_of(12'hF02), 3'd2, 16'h2F02, 1'b0);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("arst_out_data", 32'(bus.out_data), 32'd0);
        chk("arst_err_count", 32'(err_count), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;

        // Narrow counter saturates at 3
        bus2.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("sat_err_count", 32'(err_count2), 32'(sat_exp[i]));
        end
        bus2.in_valid = 1'b0;

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
